// File: rtl/mhsa_pkg.sv
// rtl/mhsa_pkg.sv - shared types and constants for the MHSA layer sequencer
package mhsa_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_NEXT,
    S_FIN,
    S_ERR
  } sched_state_e;

  localparam int LYR_LINEAR      = 0;
  localparam int LYR_QKMM        = 1;
  localparam int LYR_SOFTMAX     = 2;
  localparam int LYR_ATTMM       = 3;
  localparam int DEF_NUM_LAYERS  = 4;

endpackage

// File: rtl/mhsa_layer_sched_if.sv
// rtl/mhsa_layer_sched_if.sv - control, layer and shared memory bar signals of the sequencer
interface mhsa_layer_sched_if #(
  parameter int WIDTH      = 64,
  parameter int NUM_LAYERS = 4
) ();
  localparam int IW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic                             start;
  logic                             abort;
  logic [NUM_LAYERS-1:0]            cfg_mask;
  logic                             busy;
  logic                             done;
  logic                             err;
  logic [IW-1:0]                    cur_layer;
  logic [NUM_LAYERS-1:0]            lyr_start;
  logic [NUM_LAYERS-1:0]            lyr_done;
  logic [NUM_LAYERS-1:0]            lyr_we;
  logic [NUM_LAYERS-1:0][31:0]      lyr_addr;
  logic [NUM_LAYERS-1:0][WIDTH-1:0] lyr_wdata;
  logic                             mem_we;
  logic [31:0]                      mem_addr;
  logic [WIDTH-1:0]                 mem_wdata;

  modport master (
    output start, abort, cfg_mask, lyr_done, lyr_we, lyr_addr, lyr_wdata,
    input  busy, done, err, cur_layer, lyr_start, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  start, abort, cfg_mask, lyr_done, lyr_we, lyr_addr, lyr_wdata,
    output busy, done, err, cur_layer, lyr_start, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mhsa_layer_sched_lyr_next_find.sv
// rtl/mhsa_layer_sched_lyr_next_find.sv - lowest enabled layer, overall or strictly above cur
module lyr_next_find #(
  parameter  int NUM_LAYERS = 4,
  localparam int IW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic [NUM_LAYERS-1:0] mask,
  input  logic [IW-1:0]         cur,
  input  logic                  first,
  output logic                  found,
  output logic [IW-1:0]         idx
);

  // Scan high to low so the lowest qualifying index is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (mask[i] && (first || (i > int'(cur)))) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/mhsa_layer_sched.sv
// rtl/mhsa_layer_sched.sv - runs enabled layers in index order and owns the shared memory bar
module mhsa_layer_sched
  import mhsa_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int NUM_LAYERS = DEF_NUM_LAYERS,
  parameter int TIMEOUT    = 100000
) (
  input logic               clk,
  input logic               rst_n,
  mhsa_layer_sched_if.slave bus
);

  localparam int IW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  sched_state_e          r_state;
  sched_state_e          w_nxt_state;
  logic [IW-1:0]         r_cur_layer;
  logic [IW-1:0]         w_nxt_cur;
  logic [NUM_LAYERS-1:0] r_mask_q;
  logic [NUM_LAYERS-1:0] r_lyr_start;
  logic [TW-1:0]         r_timer;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic                  w_start_ok;
  logic                  w_cur_done;
  logic                  w_timeout;
  logic                  w_find_first;
  logic [NUM_LAYERS-1:0] w_find_mask;
  logic                  w_found;
  logic [IW-1:0]         w_find_idx;
  logic                  w_mem_we;
  logic [31:0]           w_mem_addr;
  logic [WIDTH-1:0]      w_mem_wdata;

  assign w_start_ok   = (r_state == S_IDLE) && bus.start && !bus.abort;
  assign w_cur_done   = bus.lyr_done[r_cur_layer];
  assign w_timeout    = (r_timer == TW'(TIMEOUT));
  // In IDLE the search runs on the incoming mask, afterwards on the latched one.
  assign w_find_first = (r_state == S_IDLE);
  assign w_find_mask  = w_find_first ? bus.cfg_mask : r_mask_q;

  lyr_next_find #(.NUM_LAYERS(NUM_LAYERS)) u_next_find (
    .mask  (w_find_mask),
    .cur   (r_cur_layer),
    .first (w_find_first),
    .found (w_found),
    .idx   (w_find_idx)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cur   = r_cur_layer;
    if (r_state != S_IDLE && bus.abort) begin
      w_nxt_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            if (w_found) begin
              w_nxt_cur   = w_find_idx;
              w_nxt_state = S_LAUNCH;
            end else begin
              w_nxt_state = S_FIN;
            end
          end
        end
        S_LAUNCH: w_nxt_state = S_RUN;
        S_RUN: begin
          if (w_cur_done) begin
            w_nxt_state = S_NEXT;
          end else if (w_timeout) begin
            w_nxt_state = S_ERR;
          end
        end
        S_NEXT: begin
          if (w_found) begin
            w_nxt_cur   = w_find_idx;
            w_nxt_state = S_LAUNCH;
          end else begin
            w_nxt_state = S_FIN;
          end
        end
        S_FIN:   w_nxt_state = S_IDLE;
        S_ERR:   w_nxt_state = S_IDLE;
        default: w_nxt_state = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cur_layer <= '0;
      r_mask_q    <= '0;
      r_lyr_start <= '0;
      r_timer     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_cur_layer <= w_nxt_cur;
      r_busy      <= (w_nxt_state != S_IDLE);
      r_done      <= (r_state == S_FIN) && !bus.abort;
      r_lyr_start <= '0;
      if (w_nxt_state == S_LAUNCH) begin
        r_lyr_start[w_nxt_cur] <= 1'b1;
      end
      if (w_start_ok) begin
        r_mask_q <= bus.cfg_mask;
        r_err    <= 1'b0;
      end else if (r_state == S_ERR && !bus.abort) begin
        r_err <= 1'b1;
      end
      if (r_state == S_LAUNCH) begin
        r_timer <= '0;
      end else if (r_state == S_RUN && !w_cur_done && !w_timeout) begin
        r_timer <= r_timer + TW'(1);
      end
    end
  end

  // The done cycle is still in RUN, so a write issued alongside done reaches the bar.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (r_state == S_LAUNCH || r_state == S_RUN) begin
      w_mem_we    = bus.lyr_we[r_cur_layer];
      w_mem_addr  = bus.lyr_addr[r_cur_layer];
      w_mem_wdata = bus.lyr_wdata[r_cur_layer];
    end
  end

  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.cur_layer = r_cur_layer;
  assign bus.lyr_start = r_lyr_start;

endmodule

// File: tb/tb_mhsa_layer_sched.sv
// tb/tb_mhsa_layer_sched.sv - self-checking bench for mhsa_layer_sched with a layer-start scoreboard
module tb_mhsa_layer_sched;
  import mhsa_pkg::*;

  localparam int WIDTH = 64;
  localparam int NL    = 4;
  localparam int TO    = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mhsa_layer_sched_if #(.WIDTH(WIDTH), .NUM_LAYERS(NL)) bus ();

  mhsa_layer_sched #(.WIDTH(WIDTH), .NUM_LAYERS(NL), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int owner = -1;
  int cnt[NL];
  int dly[NL];
  logic [NL-1:0] we_force = '0;
  int done_cnt = 0;
  int cyc = 0;
  bit bar_chk = 1'b1;
  int last_hand = -100;
  logic prev_busy = 1'b0;

  // One cycle: observe at the falling edge, update the layer models, re-check the bar.
  task automatic tick();
    logic [WIDTH+32:0] exp_bar;
    logic [WIDTH+32:0] got_bar;
    logic [NL-1:0] oh;
    int e;
    @(negedge clk);
    cyc++;
    if (!rst_n || bus.abort) begin
      owner = -1;
      if (!rst_n) for (int i = 0; i < NL; i++) cnt[i] = 0;
    end else if (owner >= 0 && bus.lyr_done[owner]) begin
      owner = -1;
      last_hand = cyc;
    end
    if (rst_n && bus.lyr_start != '0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL lyr_start_unexpected cyc=%0d got=%b required=none", cyc, bus.lyr_start);
      end else begin
        e = exp_q.pop_front();
        oh = '0;
        oh[e] = 1'b1;
        if (bus.lyr_start !== oh) begin
          n_bad++;
          $display("FAIL lyr_start cyc=%0d got=%b required=%b", cyc, bus.lyr_start, oh);
        end
        n_cmp++;
        if (bus.cur_layer !== 2'(e)) begin
          n_bad++;
          $display("FAIL cur_layer cyc=%0d got=%0d required=%0d", cyc, bus.cur_layer, e);
        end
        if (last_hand >= 0) begin
          n_cmp++;
          if (cyc - last_hand != 1) begin
            n_bad++;
            $display("FAIL handover cyc=%0d got=%0d required=1", cyc, cyc - last_hand);
          end
          last_hand = -100;
        end
        owner = e;
        cnt[e] = dly[e];
      end
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      n_cmp++;
      if (bus.busy !== 1'b0 || prev_busy !== 1'b1) begin
        n_bad++;
        $display("FAIL done_busy cyc=%0d got busy=%b prev=%b required busy=0 prev=1", cyc, bus.busy, prev_busy);
      end
    end
    prev_busy = bus.busy;
    if (bar_chk) begin
      exp_bar = (owner >= 0) ? {bus.lyr_we[owner], bus.lyr_addr[owner], bus.lyr_wdata[owner]} : '0;
      got_bar = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
      n_cmp++;
      if (got_bar !== exp_bar) begin
        n_bad++;
        $display("FAIL bar_pre cyc=%0d got=%h required=%h", cyc, got_bar, exp_bar);
      end
    end
    for (int i = 0; i < NL; i++) begin
      bus.lyr_done[i] = 1'b0;
      if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) bus.lyr_done[i] = 1'b1;
      end
      bus.lyr_addr[i]  = $urandom;
      bus.lyr_wdata[i] = {$urandom, $urandom};
    end
    bus.lyr_we = NL'($urandom) | we_force | bus.lyr_done;
    #1;
    if (bar_chk) begin
      exp_bar = (owner >= 0) ? {bus.lyr_we[owner], bus.lyr_addr[owner], bus.lyr_wdata[owner]} : '0;
      got_bar = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
      n_cmp++;
      if (got_bar !== exp_bar) begin
        n_bad++;
        $display("FAIL bar_post cyc=%0d got=%h required=%h", cyc, got_bar, exp_bar);
      end
    end
  endtask

  task automatic do_start(input logic [NL-1:0] m);
    bus.cfg_mask = m;
    bus.start    = 1'b1;
    last_hand    = -100;
    for (int i = 0; i < NL; i++) if (m[i]) exp_q.push_back(i);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int d0;
    d0 = done_cnt;
    for (int k = 0; k < bound && done_cnt == d0; k++) tick();
    n_cmp++;
    if (done_cnt != d0 + 1) begin
      n_bad++;
      $display("FAIL %s_done got=%0d pulses required=1", name, done_cnt - d0);
    end
  endtask

  task automatic test_reset();
    logic [WIDTH+32+3+2+NL:0] got;
    rst_n = 1'b0;
    tick();
    tick();
    got = {bus.busy, bus.done, bus.err, bus.cur_layer, bus.lyr_start, bus.mem_we, bus.mem_addr, bus.mem_wdata};
    n_cmp++;
    if (got !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%h required=0", got);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_seq();
    int d0;
    for (int i = 0; i < NL; i++) dly[i] = 10;
    d0 = done_cnt;
    do_start(4'b1111);
    n_cmp++;
    if (exp_q.size() != 3) begin
      n_bad++;
      $display("FAIL full_first_start got=%0d pending required=3", exp_q.size());
    end
    wait_done("full", 200);
    for (int k = 0; k < 3; k++) tick();
    n_cmp++;
    if (exp_q.size() != 0 || done_cnt != d0 + 1 || bus.err !== 1'b0) begin
      n_bad++;
      $display("FAIL full_end got pending=%0d done=%0d err=%b required 0/1/0", exp_q.size(), done_cnt - d0, bus.err);
    end
  endtask

  task automatic test_sparse();
    for (int i = 0; i < NL; i++) dly[i] = 5;
    do_start(4'b1010);
    wait_done("sparse", 100);
    tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL sparse_pending got=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_empty();
    int d0;
    d0 = done_cnt;
    do_start(4'b0000);
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL empty_fin got busy=%b done=%b required 1/0", bus.busy, bus.done);
    end
    tick();
    n_cmp++;
    if (bus.done !== 1'b1 || done_cnt != d0 + 1) begin
      n_bad++;
      $display("FAIL empty_done got done=%b pulses=%0d required 1/1", bus.done, done_cnt - d0);
    end
    tick();
  endtask

  task automatic test_timeout();
    int t0;
    int d0;
    dly[2] = 0;
    d0 = done_cnt;
    do_start(4'b0100);
    t0 = cyc;
    bar_chk = 1'b0;
    for (int k = 0; k < 40 && bus.err !== 1'b1; k++) tick();
    n_cmp++;
    if (bus.err !== 1'b1 || cyc - t0 < 17 || cyc - t0 > 19) begin
      n_bad++;
      $display("FAIL timeout_err got err=%b after=%0d cycles required err=1 after 17..19", bus.err, cyc - t0);
    end
    n_cmp++;
    if (bus.busy !== 1'b0 || done_cnt != d0) begin
      n_bad++;
      $display("FAIL timeout_nodone got busy=%b done=%0d required 0/0", bus.busy, done_cnt - d0);
    end
    owner = -1;
    bar_chk = 1'b1;
    tick();
    dly[0] = 4;
    do_start(4'b0001);
    n_cmp++;
    if (bus.err !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_err_clear got=%b required=0", bus.err);
    end
    wait_done("after_timeout", 50);
  endtask

  task automatic test_abort();
    int d0;
    dly[0] = 4;
    dly[1] = 0;
    d0 = done_cnt;
    last_hand = -100;
    bus.cfg_mask = 4'b0011;
    bus.start = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(1);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL abort_launch got pending=%0d required=0", exp_q.size());
    end
    for (int k = 0; k < 3; k++) tick();
    bus.abort = 1'b1;
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || done_cnt != d0) begin
      n_bad++;
      $display("FAIL abort_idle got busy=%b done=%b pulses=%0d required 0/0/0", bus.busy, bus.done, done_cnt - d0);
    end
    bus.abort = 1'b0;
    bus.cfg_mask = 4'b0001;
    exp_q.push_back(0);
    tick();
    bus.start = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_restart got pending=%0d busy=%b required 0/1", exp_q.size(), bus.busy);
    end
    wait_done("abort_restart", 50);
  endtask

  task automatic test_reset_mid_run();
    logic [WIDTH+32+3+2+NL:0] got;
    for (int i = 0; i < NL; i++) dly[i] = 0;
    we_force = '1;
    do_start(4'b0100);
    tick();
    tick();
    n_cmp++;
    if (bus.mem_we !== 1'b1 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_pre got we=%b busy=%b required 1/1", bus.mem_we, bus.busy);
    end
    rst_n = 1'b0;
    tick();
    got = {bus.busy, bus.done, bus.err, bus.cur_layer, bus.lyr_start, bus.mem_we, bus.mem_addr, bus.mem_wdata};
    n_cmp++;
    if (got !== '0) begin
      n_bad++;
      $display("FAIL rst_mid got=%h required=0", got);
    end
    rst_n = 1'b1;
    we_force = '0;
    tick();
    tick();
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.cfg_mask  = '0;
    bus.lyr_done  = '0;
    bus.lyr_we    = '0;
    bus.lyr_addr  = '0;
    bus.lyr_wdata = '0;
    for (int i = 0; i < NL; i++) begin
      cnt[i] = 0;
      dly[i] = 10;
    end
    test_reset();
    test_full_seq();
    test_sparse();
    test_empty();
    test_timeout();
    test_abort();
    test_reset_mid_run();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
